// File: rtl/board_io_pkg.sv
// board_io_pkg
// Shared definitions for the board I/O conditioning block: default
// parameter values, the counter-width helper, the parameter legality check
// and the reset stretcher state encoding.
package board_io_pkg;

  localparam int DEF_NUM_IN          = 8;
  localparam int DEF_NUM_LED         = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 10000;
  localparam int DEF_PWM_WIDTH       = 8;
  localparam int DEF_RST_HOLD_CYCLES = 16;

  // Width of a counter that must be able to hold the value max_count.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  // True when the parameter set describes a buildable block.
  function automatic bit board_io_params_ok(
    input int num_in,
    input int num_led,
    input int sync_stages,
    input int debounce_cycles,
    input int pwm_width,
    input int rst_hold_cycles
  );
    return (num_in >= 1) && (num_led >= 1) &&
           (sync_stages >= 2) && (sync_stages <= 4) &&
           (debounce_cycles >= 1) && (pwm_width >= 1) &&
           (rst_hold_cycles >= 1);
  endfunction

  // Reset stretcher states.
  typedef enum logic [1:0] {
    RST_HELD  = 2'd0,  // button pressed: counter held at full value
    RST_COUNT = 2'd1,  // button released: counting down
    RST_RUN   = 2'd2   // countdown finished: SoC out of reset
  } rst_state_e;

endpackage

// File: rtl/board_io_debounce.sv
// board_io_debounce
// One input channel: synchroniser chain, debounce counter, stable level
// register and registered edge pulses.
// Ports:
//   clk_i   block clock
//   rst_i   synchronous active-high reset
//   pad_i   raw asynchronous pin
//   level_o debounced level
//   rise_o  one-cycle pulse, first cycle level_o shows 1
//   fall_o  one-cycle pulse, first cycle level_o shows 0
module board_io_debounce
  import board_io_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pad_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  // Counter value whose increment reaches DEBOUNCE_CYCLES.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_synced;
  logic [CW-1:0]          r_cnt;
  logic                   r_stable;
  logic                   r_rise;
  logic                   r_fall;

  assign w_synced = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pad_i};
    end
  end

  // The pulse registers update on the same edge as r_stable, so a pulse
  // coincides with the first cycle of the new level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_synced == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= w_synced;
        r_cnt    <= '0;
        r_rise   <= w_synced;
        r_fall   <= ~w_synced;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level_o = r_stable;
  assign rise_o  = r_rise;
  assign fall_o  = r_fall;

endmodule

// File: rtl/board_io_ctrl.sv
// board_io_ctrl
// Board pin conditioning: debounced inputs with edge events and sticky
// pending flags, per-LED PWM with period-aligned duty updates, and a
// stretched, synchronised SoC reset from the board reset button.
// Ports:
//   clk_i, rst_i        block clock, synchronous active-high reset
//   pad_in_i            raw board inputs
//   in_level_o          debounced levels
//   in_rise_o/in_fall_o one-cycle edge pulses
//   event_pending_o     sticky edge-seen flags, cleared by event_clr_i
//   led_duty_i          packed per-LED duty, led_en_i per-LED enable
//   led_o               registered PWM LED drive
//   pad_reset_n_i       raw reset button (active-low)
//   soc_rst_no          conditioned SoC reset (active-low)
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int NUM_IN          = DEF_NUM_IN,
  parameter int NUM_LED         = DEF_NUM_LED,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PWM_WIDTH       = DEF_PWM_WIDTH,
  parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_IN-1:0]              pad_in_i,
  output logic [NUM_IN-1:0]              in_level_o,
  output logic [NUM_IN-1:0]              in_rise_o,
  output logic [NUM_IN-1:0]              in_fall_o,
  output logic [NUM_IN-1:0]              event_pending_o,
  input  logic [NUM_IN-1:0]              event_clr_i,
  input  logic [NUM_LED*PWM_WIDTH-1:0]   led_duty_i,
  input  logic [NUM_LED-1:0]             led_en_i,
  output logic [NUM_LED-1:0]             led_o,
  input  logic                           pad_reset_n_i,
  output logic                           soc_rst_no
);

  // Elaboration-time parameter legality check.
  if (!board_io_params_ok(NUM_IN, NUM_LED, SYNC_STAGES, DEBOUNCE_CYCLES,
                          PWM_WIDTH, RST_HOLD_CYCLES)) begin : g_bad_params
    $error("board_io_ctrl: illegal parameter combination");
  end

  // ---------------------------------------------------------------- inputs
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
    logic w_rise;
    logic w_fall;
    logic r_pend;

    board_io_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .pad_i  (pad_in_i[gi]),
      .level_o(in_level_o[gi]),
      .rise_o (w_rise),
      .fall_o (w_fall)
    );

    // A new edge beats a simultaneous clear so no event is lost.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_pend <= 1'b0;
      end else begin
        r_pend <= (r_pend & ~event_clr_i[gi]) | w_rise | w_fall;
      end
    end

    assign in_rise_o[gi]       = w_rise;
    assign in_fall_o[gi]       = w_fall;
    assign event_pending_o[gi] = r_pend;
  end

  // ------------------------------------------------------------------- PWM
  localparam logic [PWM_WIDTH-1:0] PWM_MAX = '1;

  logic [PWM_WIDTH-1:0] r_pwm_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_WIDTH'(1);
    end
  end

  for (genvar gi = 0; gi < NUM_LED; gi++) begin : g_led
    logic [PWM_WIDTH-1:0] r_shadow;
    logic                 r_led;

    // Shadow duty only changes on the last count of a period, so the
    // compare below never sees a duty change mid-period.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_shadow <= '0;
        r_led    <= 1'b0;
      end else begin
        if (r_pwm_cnt == PWM_MAX) begin
          r_shadow <= led_duty_i[gi*PWM_WIDTH +: PWM_WIDTH];
        end
        r_led <= led_en_i[gi] & (r_pwm_cnt < r_shadow);
      end
    end

    assign led_o[gi] = r_led;
  end

  // --------------------------------------------------------- reset stretch
  localparam int HW = cnt_width(RST_HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(RST_HOLD_CYCLES);

  logic [SYNC_STAGES-1:0] r_btn_sync;
  logic                   w_btn_released;
  rst_state_e             r_state;
  rst_state_e             w_state_next;
  logic [HW-1:0]          r_hold;
  logic [HW-1:0]          w_hold_next;
  logic                   r_soc_rst_n;
  logic                   w_soc_rst_n_next;

  // Chain resets to 0, i.e. the button is treated as pressed until the
  // real pin level has propagated through.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_btn_sync <= '0;
    end else begin
      r_btn_sync <= {r_btn_sync[SYNC_STAGES-2:0], pad_reset_n_i};
    end
  end

  assign w_btn_released = r_btn_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= RST_HELD;
      r_hold      <= HOLD_LOAD;
      r_soc_rst_n <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_hold      <= w_hold_next;
      r_soc_rst_n <= w_soc_rst_n_next;
    end
  end

  // A press in any state reloads the counter; release is only signalled
  // one cycle after the counter has reached zero.
  always_comb begin
    w_state_next     = r_state;
    w_hold_next      = r_hold;
    w_soc_rst_n_next = 1'b0;
    if (!w_btn_released) begin
      w_state_next = RST_HELD;
      w_hold_next  = HOLD_LOAD;
    end else begin
      unique case (r_state)
        RST_HELD, RST_COUNT: begin
          if (r_hold == '0) begin
            w_state_next     = RST_RUN;
            w_soc_rst_n_next = 1'b1;
          end else begin
            w_state_next = RST_COUNT;
            w_hold_next  = r_hold - HW'(1);
          end
        end
        RST_RUN: begin
          w_soc_rst_n_next = 1'b1;
        end
        default: begin
          w_state_next = RST_HELD;
          w_hold_next  = HOLD_LOAD;
        end
      endcase
    end
  end

  assign soc_rst_no = r_soc_rst_n;

endmodule
